divider_stb_initiator: RTL and testbench

// - Initiator side of the divider's stb/ack handshake: takes a job (a, b, tag) from a valid/ready stream,

---
 rtl/div_init_pkg.sv | 31 +++
 rtl/divider_stb_initiator.sv | 177 +++++++++++++++++
 tb/tb_divider_stb_initiator.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_init_pkg.sv
// Shared types and constants for the divider stb/ack initiator.
package div_init_pkg;

    // Default operand and tag widths (IEEE-754 single, 4-bit tag).
    localparam int DIV_WIDTH = 32;
    localparam int DIV_TAG_W = 4;

    // Quiet NaN returned when the watchdog abandons a job.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_Z,
        RESULT
    } state_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] a;
        logic [DIV_WIDTH-1:0] b;
        logic [DIV_TAG_W-1:0] tag;
    } job_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] a;
        logic [DIV_WIDTH-1:0] b;
        logic [DIV_WIDTH-1:0] z;
        logic [DIV_TAG_W-1:0] tag;
    } res_t;

endpackage

// File: rtl/divider_stb_initiator.sv
// Initiator for the divider's stb/ack handshake: accepts a job (a, b, tag),
// pushes a and b to the divider, collects z and returns {a, b, z, tag}.
// Optional watchdog on the divider response: define DIV_INIT_TIMEOUT_EN.
module divider_stb_initiator
    import div_init_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    // job stream
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [WIDTH-1:0] job_a,
    input  logic [WIDTH-1:0] job_b,
    input  logic [TAG_W-1:0] job_tag,
    // divider operand ports
    output logic [WIDTH-1:0] div_a,
    output logic             div_a_stb,
    input  logic             div_a_ack,
    output logic [WIDTH-1:0] div_b,
    output logic             div_b_stb,
    input  logic             div_b_ack,
    // divider result port
    input  logic [WIDTH-1:0] div_z,
    input  logic             div_z_stb,
    output logic             div_z_ack,
    // result stream
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b,
    output logic [WIDTH-1:0] res_z,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic [15:0]      jobs_done
);

    // Watchdog counter type; wide enough to hold TIMEOUT_CYC.
    typedef logic [$clog2(TIMEOUT_CYC + 1)-1:0] wdog_cnt_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag_q;

    logic job_accept;
    logic a_done;
    logic b_done;

    // Operands stay in one register set: stable on the divider ports during
    // SEND and echoed on the result port during RESULT.
    assign div_a   = a_q;
    assign div_b   = b_q;
    assign res_a   = a_q;
    assign res_b   = b_q;
    assign res_tag = tag_q;

    // job_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign job_accept = job_valid && job_ready;

    // An operand is done once its stb has dropped or is completing this edge.
    assign a_done = !div_a_stb || div_a_ack;
    assign b_done = !div_b_stb || div_b_ack;

`ifdef DIV_INIT_TIMEOUT_EN
    wdog_cnt_t wdog_cnt;
    logic      wdog_fire;

    // Fire on the TIMEOUT_CYC-th cycle spent in SEND/WAIT_Z; a z transfer
    // landing on that same edge still completes normally.
    assign wdog_fire = ((state == SEND) ||
                        (state == WAIT_Z && !(div_z_stb && div_z_ack))) &&
                       (wdog_cnt == wdog_cnt_t'(TIMEOUT_CYC - 1));

    // Watchdog counter and error flag; both restart with every accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            res_err  <= 1'b0;
        end else begin
            if (job_accept) begin
                wdog_cnt <= '0;
                res_err  <= 1'b0;
            end else if (state == SEND || state == WAIT_Z) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_fire) begin
                res_err <= 1'b1;
            end
        end
    end
`else
    assign res_err = 1'b0;
`endif

    // Handshake sequencer: every output strobe/ack is a register set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: job_ready is a flop cleared by reset, so it reads 0 while
            // rst_n is low and rises on the first clock edge in IDLE.
            state     <= IDLE;
            job_ready <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            div_a_stb <= 1'b0;
            div_b_stb <= 1'b0;
            div_z_ack <= 1'b0;
            res_valid <= 1'b0;
            res_z     <= '0;
            jobs_done <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the watchdog override
            // after the case relies on the last assignment winning.
            case (state)
                IDLE: begin
                    if (job_accept) begin
                        a_q       <= job_a;
                        b_q       <= job_b;
                        tag_q     <= job_tag;
                        div_a_stb <= 1'b1;
                        div_b_stb <= 1'b1;
                        job_ready <= 1'b0;
                        state     <= SEND;
                    end else begin
                        job_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (div_a_stb && div_a_ack) begin
                        div_a_stb <= 1'b0;
                    end
                    if (div_b_stb && div_b_ack) begin
                        div_b_stb <= 1'b0;
                    end
                    if (a_done && b_done) begin
                        div_z_ack <= 1'b1;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (div_z_stb && div_z_ack) begin
                        res_z     <= div_z;
                        div_z_ack <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        jobs_done <= jobs_done + 1'b1;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef DIV_INIT_TIMEOUT_EN
            if (wdog_fire) begin
                div_a_stb <= 1'b0;
                div_b_stb <= 1'b0;
                div_z_ack <= 1'b0;
                res_z     <= WIDTH'(FP_QNAN);
                res_valid <= 1'b1;
                state     <= RESULT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_divider_stb_initiator.sv
// Self-checking bench for divider_stb_initiator. The bench plays the divider
// (acks and z are driven from tasks) and the job source / result consumer.
// Expected results go into a scoreboard queue when a job is offered and are
// compared when the DUT hands the result off.
// The watchdog scenario is compiled in when DIV_INIT_TIMEOUT_EN is defined.
module tb_divider_stb_initiator;
    import div_init_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [W-1:0]  job_a;
    logic [W-1:0]  job_b;
    logic [TW-1:0] job_tag;
    logic [W-1:0]  div_a;
    logic          div_a_stb;
    logic          div_a_ack;
    logic [W-1:0]  div_b;
    logic          div_b_stb;
    logic          div_b_ack;
    logic [W-1:0]  div_z;
    logic          div_z_stb;
    logic          div_z_ack;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_a;
    logic [W-1:0]  res_b;
    logic [W-1:0]  res_z;
    logic [TW-1:0] res_tag;
    logic          res_err;
    logic [15:0]   jobs_done;

    int     n_checks = 0;
    int     n_pass   = 0;
    logic [15:0] exp_done = '0;
    res_t   sb_q[$];

    divider_stb_initiator #(
        .WIDTH      (W),
        .TAG_W      (TW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_a    (job_a),
        .job_b    (job_b),
        .job_tag  (job_tag),
        .div_a    (div_a),
        .div_a_stb(div_a_stb),
        .div_a_ack(div_a_ack),
        .div_b    (div_b),
        .div_b_stb(div_b_stb),
        .div_b_ack(div_b_ack),
        .div_z    (div_z),
        .div_z_stb(div_z_stb),
        .div_z_ack(div_z_ack),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_a    (res_a),
        .res_b    (res_b),
        .res_z    (res_z),
        .res_tag  (res_tag),
        .res_err  (res_err),
        .jobs_done(jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer a job at the current negedge, wait (bounded) for acceptance.
    task automatic send_job(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TW-1:0] tag, input logic [W-1:0] z);
        res_t e;
        int   w;
        e.a   = a;
        e.b   = b;
        e.z   = z;
        e.tag = tag;
        sb_q.push_back(e);
        job_a     = a;
        job_b     = b;
        job_tag   = tag;
        job_valid = 1'b1;
        w = 0;
        while (!job_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
        job_a     = 32'hFFFF_FFFF;
        job_b     = 32'hFFFF_FFFF;
        check("ready_low_after_accept", 32'(job_ready), 32'd0);
    endtask

    // Divider side of the operand transfer. Each ack rises a_dly/b_dly cycles
    // after the stb and then stays high, so it also exercises ack-without-stb.
    task automatic send_phase(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int a_dly, input int b_dly, input bit spur);
        int last;
        last = (a_dly > b_dly) ? a_dly : b_dly;
        for (int c = 0; c <= last; c++) begin
            check("a_stb", 32'(div_a_stb), 32'(c <= a_dly));
            check("b_stb", 32'(div_b_stb), 32'(c <= b_dly));
            check("div_a_stable", div_a, a);
            check("div_b_stable", div_b, b);
            check("z_ack_in_send", 32'(div_z_ack), 32'd0);
            div_a_ack = (c >= a_dly);
            div_b_ack = (c >= b_dly);
            div_z_stb = spur;
            if (spur) div_z = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        div_a_ack = 1'b0;
        div_b_ack = 1'b0;
        div_z_stb = 1'b0;
        check("a_stb_done", 32'(div_a_stb), 32'd0);
        check("b_stb_done", 32'(div_b_stb), 32'd0);
        check("z_ack_wait", 32'(div_z_ack), 32'd1);
    endtask

    // Divider returns z after z_lat cycles in WAIT_Z.
    task automatic wait_z(input logic [W-1:0] z, input int z_lat);
        for (int i = 0; i < z_lat; i++) begin
            check("z_ack_held", 32'(div_z_ack), 32'd1);
            check("no_res_yet", 32'(res_valid), 32'd0);
            @(negedge clk);
        end
        div_z     = z;
        div_z_stb = 1'b1;
        @(negedge clk);
        div_z_stb = 1'b0;
        div_z     = 32'h0BAD_F00D;
        check("z_ack_drop", 32'(div_z_ack), 32'd0);
        check("res_valid_up", 32'(res_valid), 32'd1);
    endtask

    // Consumer holds res_ready low for `hold` cycles, then takes the result.
    task automatic take_result(input int hold, input logic exp_err);
        res_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: result with no expected entry at %0t", $time);
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_job_ready", 32'(job_ready), 32'd0);
            check("hold_res_z", res_z, e.z);
            check("hold_res_a", res_a, e.a);
            @(negedge clk);
        end
        res_ready = 1'b1;
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_a", res_a, e.a);
        check("res_b", res_b, e.b);
        check("res_z", res_z, e.z);
        check("res_tag", 32'(res_tag), 32'(e.tag));
        check("res_err", 32'(res_err), 32'(exp_err));
        @(negedge clk);
        res_ready = 1'b0;
        exp_done  = exp_done + 16'd1;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("idle_ready", 32'(job_ready), 32'd1);
        check("jobs_done", 32'(jobs_done), 32'(exp_done));
    endtask

    initial begin
        res_t dropped;
        int   k;
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_a     = '0;
        job_b     = '0;
        job_tag   = '0;
        div_a_ack = 1'b0;
        div_b_ack = 1'b0;
        div_z     = '0;
        div_z_stb = 1'b0;
        res_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_job_ready", 32'(job_ready), 32'd0);
        check("rst_a_stb", 32'(div_a_stb), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_jobs_done", 32'(jobs_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(job_ready), 32'd1);

        // 1.0 / 2.0, acks one cycle after the stb.
        send_job(32'h3F80_0000, 32'h4000_0000, 4'h5, 32'h3F00_0000);
        send_phase(32'h3F80_0000, 32'h4000_0000, 1, 1, 1'b0);
        wait_z(32'h3F00_0000, 2);
        take_result(0, 1'b0);

        // 6.0 / 3.0, b acked five cycles before a.
        send_job(32'h40C0_0000, 32'h4040_0000, 4'hA, 32'h4000_0000);
        send_phase(32'h40C0_0000, 32'h4040_0000, 6, 1, 1'b0);
        wait_z(32'h4000_0000, 1);
        take_result(0, 1'b0);

        // 42.0 / 7.0, both acked together; consumer stalls 20 cycles.
        send_job(32'h4228_0000, 32'h40E0_0000, 4'h3, 32'h40C0_0000);
        send_phase(32'h4228_0000, 32'h40E0_0000, 0, 0, 1'b0);
        wait_z(32'h40C0_0000, 0);
        take_result(20, 1'b0);

        // 10.0 / 5.0 with a bogus z_stb during SEND that must be ignored.
        send_job(32'h4120_0000, 32'h40A0_0000, 4'h7, 32'h4000_0000);
        send_phase(32'h4120_0000, 32'h40A0_0000, 2, 2, 1'b1);
        wait_z(32'h4000_0000, 3);
        take_result(0, 1'b0);

        // Reset asserted mid-job in WAIT_Z: outputs clear asynchronously.
        send_job(32'h4080_0000, 32'h4000_0000, 4'hC, 32'h4000_0000);
        send_phase(32'h4080_0000, 32'h4000_0000, 0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_z_ack", 32'(div_z_ack), 32'd0);
        check("arst_job_ready", 32'(job_ready), 32'd0);
        check("arst_jobs_done", 32'(jobs_done), 32'd0);
        check("arst_div_a", div_a, 32'd0);
        check("arst_res_tag", 32'(res_tag), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        dropped  = sb_q.pop_back();
        exp_done = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_arst", 32'(job_ready), 32'd1);

        // 1.0 / 1.0 after the mid-job reset.
        send_job(32'h3F80_0000, 32'h3F80_0000, 4'h1, 32'h3F80_0000);
        send_phase(32'h3F80_0000, 32'h3F80_0000, 1, 0, 1'b0);
        wait_z(32'h3F80_0000, 1);
        take_result(0, 1'b0);

`ifdef DIV_INIT_TIMEOUT_EN
        // Divider accepts operands but never returns z.
        send_job(32'h4040_0000, 32'h4000_0000, 4'h9, FP_QNAN);
        div_a_ack = 1'b1;
        div_b_ack = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            div_a_ack = 1'b0;
            div_b_ack = 1'b0;
        end while (!res_valid && k < 64);
        check("wdog_cycles", 32'(k), 32'd16);
        take_result(0, 1'b1);
`else
        k = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
